relu_stream_ctrl: RTL
=====================

RELU_STREAM_CTRL -- requirements
Module: relu_stream_ctrl

Interface
REQ-001 Parameters SHALL be exactly:
  - DATA_WIDTH, 8, element width in bits (signed two's complement).
  - MAP_W, 28, feature-map columns.
  - MAP_H, 28, feature-map rows.
  - CHANNELS, 6, feature-map channels.
  - ADDR_WIDTH, 13, read-address width; TOTAL = MAP_W*MAP_H*CHANNELS SHALL be <= 2^ADDR_WIDTH.
REQ-002 Ports SHALL be exactly:
  - clk  input  1  single clock; all state updates on the rising edge.
  - rst_n  input  1  asynchronous, active-low reset.
  - start  input  1  one-cycle request to process one full map.
  - busy  output  1  high whenever state != IDLE.
  - done  output  1  one-cycle completion pulse.
  - rd_en  output  1  feature-buffer read strobe.
  - rd_addr  output  ADDR_WIDTH  read address, valid when rd_en=1.
  - rd_data  input  DATA_WIDTH  buffer data, valid one cycle after rd_en.
  - relu_din  output  DATA_WIDTH  drive to the external 1-cycle-latency ReLU.
  - relu_dout  input  DATA_WIDTH  ReLU result, valid one cycle after relu_din.
  - out_valid  output  1  stream data valid.
  - out_ready  input  1  downstream accept.
  - out_data  output  DATA_WIDTH  stream data.
  - out_last  output  1  marks element TOTAL-1.

Function
REQ-003 States SHALL be IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE->RUN SHALL occur on the edge sampling start=1; the read address counter SHALL be cleared to 0 on that edge.
REQ-005 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-006 In RUN, rd_en SHALL be asserted when addr < TOTAL and (in-flight reads + FIFO count) < 4.
REQ-007 rd_addr SHALL equal the address counter, which SHALL increment by 1 on each cycle with rd_en=1.
REQ-008 relu_din SHALL be rd_data combinationally.
REQ-009 relu_dout SHALL be captured into a 4-entry output FIFO exactly two cycles after the matching rd_en.
REQ-010 The tag for element TOTAL-1 SHALL travel with it and drive out_last when that element is at the FIFO head.
REQ-011 out_valid SHALL be high iff the FIFO is non-empty; out_data/out_last SHALL be the head entry.
REQ-012 The head SHALL pop when out_valid && out_ready.
REQ-013 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-014 A simultaneous push and pop SHALL leave the FIFO count unchanged.
REQ-015 The credit rule (REQ-006) SHALL guarantee that the FIFO never overflows; no write SHALL ever be dropped.
REQ-016 RUN->DRAIN SHALL occur on the edge issuing the read of address TOTAL-1.
REQ-017 DRAIN->DONE SHALL occur on the edge popping the out_last element.
REQ-018 In DONE, done=1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-019 With out_ready held high, out_valid SHALL first rise three edges after the edge sampling start, and the block SHALL sustain one element per cycle.
REQ-020 Address and counters SHALL be unsigned; the address counter SHALL not wrap past TOTAL.

Reset
REQ-021 On rst_n=0, asynchronously:
  - state SHALL be IDLE;
  - address counter, in-flight count and FIFO SHALL be cleared;
  - busy, done, rd_en, out_valid and out_last SHALL be 0;
  - rd_addr and out_data SHALL be 0.
REQ-022 Reset asserted mid-operation SHALL abort the map with no done pulse; the next start after release SHALL begin at address 0.

Verification (MAP_W=4, MAP_H=2, CHANNELS=1, TOTAL=8)
REQ-023 Nominal: buffer holds {-3,5,0,-128,127,1,-1,2}, out_ready=1, single start -> stream {0,5,0,0,127,1,0,2} on consecutive cycles, out_last on the 8th element, done one cycle after the last pop.
REQ-024 Backpressure: out_ready=0 for 10 cycles after start -> exactly 4 reads issued, out_data holds the first element; after release, all 8 values appear in order with no loss or duplication.
REQ-025 Random out_ready (50%) -> output sequence identical to REQ-023; FIFO count never exceeds 4.
REQ-026 start pulsed again during RUN and DRAIN -> ignored; exactly 8 outputs and one done pulse.
REQ-027 rst_n low after 3 elements are output -> all outputs 0 immediately, no done; a new start yields the full 8-element sequence from address 0.
REQ-028 Back-to-back: start asserted in the cycle after done -> the second map streams correctly, and busy is low for exactly one cycle between maps.

Source files
------------

// File: rtl/relu_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : relu_stream_ctrl
// Description : Walks a feature map held in an external buffer, feeds each
//               element through an external 1-cycle-latency ReLU, and emits the
//               results as a valid/ready stream. A 4-entry output FIFO plus a
//               credit check on outstanding reads keeps backpressure lossless.
// Ports       :
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle request to process one full map (IDLE only)
//   busy       - high whenever the controller is not idle
//   done       - one-cycle completion pulse
//   rd_en      - feature-buffer read strobe
//   rd_addr    - read address (valid with rd_en)
//   rd_data    - buffer data, one cycle after rd_en
//   relu_din   - operand to the external ReLU (rd_data passed through)
//   relu_dout  - ReLU result, one cycle after relu_din
//   out_valid  - stream data valid (FIFO non-empty)
//   out_ready  - downstream accept
//   out_data   - stream data (FIFO head)
//   out_last   - marks the final element of the map
// Revision    : 1.0 - initial release
// ============================================================================
module relu_stream_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAP_W      = 28,
  parameter int MAP_H      = 28,
  parameter int CHANNELS   = 6,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] relu_din,
  input  logic [DATA_WIDTH-1:0] relu_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int TOTAL = MAP_W * MAP_H * CHANNELS;
  // One extra bit so the counter can rest at TOTAL even when
  // TOTAL == 2**ADDR_WIDTH.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [2:0]       FIFO_DEPTH = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]      addr_cnt;
  // pipe_vld[0]: read data on rd_data; pipe_vld[1]: result on relu_dout.
  logic [1:0]            pipe_vld;
  logic [1:0]            pipe_last;
  logic [DATA_WIDTH-1:0] fifo_data [4];
  logic [3:0]            fifo_last;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_cnt;

  logic [2:0] credit_used;
  logic       issue;
  logic       issue_last;
  logic       push;
  logic       pop;

  // Every read in flight already owns a FIFO slot, so the FIFO cannot
  // overflow no matter how long out_ready stays low.
  assign credit_used = {2'b00, pipe_vld[0]} + {2'b00, pipe_vld[1]} + fifo_cnt;
  assign issue       = (state == RUN) && (addr_cnt < TOTAL_C) && (credit_used < FIFO_DEPTH);
  assign issue_last  = issue && (addr_cnt == LAST_C);
  assign push        = pipe_vld[1];
  assign pop         = out_valid && out_ready;

  assign rd_en     = issue;
  assign rd_addr   = addr_cnt[ADDR_WIDTH-1:0];
  assign relu_din  = rd_data;
  assign out_valid = (fifo_cnt != 3'd0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (issue_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read address counter and read-latency tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt  <= '0;
      pipe_vld  <= 2'b00;
      pipe_last <= 2'b00;
    end else begin
      if ((state == IDLE) && start) begin
        addr_cnt <= '0;
      end else if (issue) begin
        addr_cnt <= addr_cnt + 1'b1;
      end
      pipe_vld  <= {pipe_vld[0], issue};
      pipe_last <= {pipe_last[0], issue_last};
    end
  end

  // --------------------------------------------------------------------------
  // 4-entry output FIFO; the last-element tag rides alongside the data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_data[i] <= '0;
      end
      fifo_last <= 4'b0000;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      fifo_cnt  <= 3'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= relu_dout;
        fifo_last[wr_ptr] <= pipe_last[1];
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire
